uart_tx_fifo: RTL and testbench

Buffered transmit front-end placed directly upstream of `uart_tx`, clocked by the same clock that drives `uart_tx`. It accepts bytes from the host at up to one per cycle into a circular FIFO. It hands them to `uart_tx` one at a time through a strobe/busy handshake, so the host no longer has to hold `wr_i` and watch `TX_busy_o` itself. Each byte leaves the FIFO only once `uart_tx` has shown busy, so a strobe the transmitter does not take loses no data.

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/uart_tx_fifo_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 104 ++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmit front-end:
// handshake FSM state encodings and the default FIFO depth.
package uart_tx_fifo_pkg;

    localparam int UART_FIFO_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STROBE    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte FIFO with separate occupancy counter; a write while full
// is accepted only if a pop happens in the same cycle, otherwise dropped.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
    parameter int DATA_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  wr_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    output logic [DATA_W-1:0]     head_o
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign push    = wr_i && (!full_o || pop_i);

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_i && full_o && !pop_i;
        if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign head_o     = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end: queues host bytes and feeds uart_tx through a
// strobe/busy handshake, popping a byte only once the transmitter shows busy.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2   = UART_FIFO_DEPTH_LOG2,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                wr_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                overflow_o,
    output logic                retry_o,
    output logic [DATA_W-1:0]   tx_data_o,
    output logic                tx_wr_o,
    input  logic                tx_busy_i
);

    localparam int              TO_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BUSY_TIMEOUT);

    tx_state_e       state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic            tx_wr_q, tx_wr_d;
    logic            retry_q, retry_d;
    logic            pop;
    logic            timeout_hit;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .wr_i       (wr_i),
        .pop_i      (pop),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .head_o     (tx_data_o)
    );

    // Saturating increment; the timeout fires on the edge the count reaches BUSY_TIMEOUT.
    assign to_cnt_inc  = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
    assign timeout_hit = (to_cnt_inc == TO_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            tx_wr_q  <= 1'b0;
            retry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            tx_wr_q  <= tx_wr_d;
            retry_q  <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!empty_o && !tx_busy_i) state_d = STROBE;
            STROBE:    state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy_i)        state_d = WAIT_DONE;
                else if (timeout_hit) state_d = IDLE;
            end
            WAIT_DONE: if (!tx_busy_i) state_d = IDLE;
        endcase
    end

    // Registered strobe follows the state, so it is high exactly while in STROBE.
    always_comb begin
        pop      = 1'b0;
        to_cnt_d = to_cnt_q;
        retry_d  = 1'b0;
        tx_wr_d  = (state_d == STROBE);
        unique case (state_q)
            STROBE:    to_cnt_d = '0;
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    pop = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    retry_d  = timeout_hit;
                end
            end
            default: ;
        endcase
    end

    assign tx_wr_o = tx_wr_q;
    assign retry_o = retry_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple uart_tx responder model.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int FRAME = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = '0;
    logic       wr_i = 1'b0;
    logic       full_o, empty_o, overflow_o, retry_o, tx_wr_o, tx_busy_i;
    logic [4:0] count_o;
    logic [7:0] tx_data_o;

    uart_tx_fifo #(
        .DEPTH_LOG2   (4),
        .DATA_W       (8),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .wr_i       (wr_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .retry_o    (retry_o),
        .tx_data_o  (tx_data_o),
        .tx_wr_o    (tx_wr_o),
        .tx_busy_i  (tx_busy_i)
    );

    always #5 clk_i = ~clk_i;

    // Transmitter model: takes a strobe when idle and enabled, then stays busy FRAME cycles.
    int         busy_cnt = 0;
    logic       model_en = 1'b0;
    logic       tx_wr_prev = 1'b0;
    int         b2b = 0;
    logic [7:0] rx_q[$];

    assign tx_busy_i = (busy_cnt != 0);

    always @(posedge clk_i) begin
        tx_wr_prev <= tx_wr_o;
        if (tx_wr_o && tx_wr_prev) b2b <= b2b + 1;
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (model_en && tx_wr_o) begin
            busy_cnt <= FRAME;
            rx_q.push_back(tx_data_o);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        data_i = d;
        wr_i   = 1'b1;
        step();
        wr_i   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(count_o == 5'd0 && !tx_busy_i && dut.state_q == IDLE) && n < 3000) begin
            step();
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
    endtask

    int         base;
    int         n;
    logic [7:0] exp_q[$];

    initial begin
        // Reset state
        repeat (2) step();
        rst_i = 1'b0;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_tx_wr", 32'(tx_wr_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_retry", 32'(retry_o), 32'd0);

        // Single byte: strobe two edges after the write, pop on the busy edge
        model_en = 1'b1;
        base = rx_q.size();
        write_byte(8'hAA);
        check("single_count_after_write", 32'(count_o), 32'd1);
        check("single_empty_after_write", 32'(empty_o), 32'd0);
        check("single_tx_wr_early", 32'(tx_wr_o), 32'd0);
        step();
        check("single_tx_wr", 32'(tx_wr_o), 32'd1);
        check("single_tx_data", 32'(tx_data_o), 32'hAA);
        step();
        check("single_tx_wr_drop", 32'(tx_wr_o), 32'd0);
        check("single_busy_seen", 32'(tx_busy_i), 32'd1);
        check("single_count_before_pop", 32'(count_o), 32'd1);
        step();
        check("single_count_after_pop", 32'(count_o), 32'd0);
        check("single_rx_size", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) check("single_rx_data", 32'(rx_q[base]), 32'hAA);
        drain("single_drain");

        // Burst 16 bytes with the transmitter disabled, then overflow
        model_en = 1'b0;
        base = rx_q.size();
        for (int i = 1; i <= 16; i++) begin
            data_i = 8'(i);
            wr_i   = 1'b1;
            step();
        end
        wr_i = 1'b0;
        check("burst_full", 32'(full_o), 32'd1);
        check("burst_count", 32'(count_o), 32'd16);
        check("burst_no_overflow", 32'(overflow_o), 32'd0);
        write_byte(8'hEE);
        check("burst_overflow_pulse", 32'(overflow_o), 32'd1);
        check("burst_count_after_drop", 32'(count_o), 32'd16);
        step();
        check("burst_overflow_clear", 32'(overflow_o), 32'd0);

        // Push and pop in the same cycle while full
        model_en = 1'b1;
        n = 0;
        while (!(dut.state_q == WAIT_BUSY && tx_busy_i) && n < 200) begin
            step();
            n++;
        end
        check("pushpop_reach_pop", 32'(n < 200), 32'd1);
        check("pushpop_full_before", 32'(full_o), 32'd1);
        write_byte(8'h55);
        check("pushpop_count", 32'(count_o), 32'd16);
        check("pushpop_no_overflow", 32'(overflow_o), 32'd0);
        check("pushpop_full_after", 32'(full_o), 32'd1);
        drain("burst_drain");
        check("burst_rx_size", 32'(rx_q.size() - base), 32'd17);
        if (rx_q.size() - base == 17) begin
            for (int i = 0; i < 16; i++) check($sformatf("burst_rx_%0d", i), 32'(rx_q[base + i]), 32'(i + 1));
            check("burst_rx_55", 32'(rx_q[base + 16]), 32'h55);
        end

        // Busy timeout: no busy after the strobe, retry after 15 WAIT_BUSY cycles
        model_en = 1'b0;
        write_byte(8'h77);
        n = 0;
        while (!tx_wr_o && n < 10) begin
            step();
            n++;
        end
        check("timeout_first_strobe", 32'(tx_wr_o), 32'd1);
        check("timeout_first_data", 32'(tx_data_o), 32'h77);
        repeat (15) step();
        check("timeout_no_retry_yet", 32'(retry_o), 32'd0);
        check("timeout_state_wait", 32'(dut.state_q), 32'(WAIT_BUSY));
        step();
        check("timeout_retry_pulse", 32'(retry_o), 32'd1);
        check("timeout_count_kept", 32'(count_o), 32'd1);
        check("timeout_state_idle", 32'(dut.state_q), 32'(IDLE));
        step();
        check("timeout_retry_clear", 32'(retry_o), 32'd0);
        check("timeout_restrobe", 32'(tx_wr_o), 32'd1);
        check("timeout_restrobe_data", 32'(tx_data_o), 32'h77);
        model_en = 1'b1;
        drain("timeout_drain");
        check("timeout_rx_last", 32'(rx_q[rx_q.size() - 1]), 32'h77);

        // Reset while in WAIT_DONE with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            data_i = 8'hA0 + 8'(i);
            wr_i   = 1'b1;
            step();
        end
        wr_i = 1'b0;
        check("midrst_count_before", 32'(count_o), 32'd5);
        check("midrst_state_before", 32'(dut.state_q), 32'(WAIT_DONE));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_count", 32'(count_o), 32'd0);
        check("midrst_empty", 32'(empty_o), 32'd1);
        check("midrst_full", 32'(full_o), 32'd0);
        check("midrst_tx_wr", 32'(tx_wr_o), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        drain("midrst_drain");

        // Stream 40 bytes with random host gaps across several pointer wraps
        base = rx_q.size();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) step();
            n = 0;
            while (full_o && n < 200) begin
                step();
                n++;
            end
            write_byte(8'(i * 37 + 5));
            exp_q.push_back(8'(i * 37 + 5));
        end
        drain("wrap_drain");
        check("wrap_rx_size", 32'(rx_q.size() - base), 32'd40);
        if (rx_q.size() - base == 40) begin
            for (int i = 0; i < 40; i++) check($sformatf("wrap_rx_%0d", i), 32'(rx_q[base + i]), 32'(exp_q[i]));
        end

        check("tx_wr_back_to_back", 32'(b2b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
